bc_serial_tx_fifo: RTL



---
 rtl/bc_serial_tx_fifo_if.sv | 30 +++
 rtl/bc_serial_tx_fifo.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bc_serial_tx_fifo_if.sv
// rtl/bc_serial_tx_fifo_if.sv - signal bundle for bc_serial_tx_fifo
//   master: producer/config side (drives CfgDiv, DivIn, PushValid, PushData)
//   slave : the FIFO/serialiser (drives PushReady, Level, Busy, ClkTx, DoutValid, DataOut)
interface bc_serial_tx_fifo_if #(
  parameter int DWIDTH  = 32,
  parameter int SBITS   = 4,
  parameter int DEPTH   = 4,
  parameter int DIVBITS = 8
);
  logic                       CfgDiv;
  logic [DIVBITS-1:0]         DivIn;
  logic                       PushValid;
  logic [DWIDTH-1:0]          PushData;
  logic                       PushReady;
  logic [$clog2(DEPTH+1)-1:0] Level;
  logic                       Busy;
  logic                       ClkTx;
  logic                       DoutValid;
  logic [SBITS-1:0]           DataOut;

  modport master (
    output CfgDiv, DivIn, PushValid, PushData,
    input  PushReady, Level, Busy, ClkTx, DoutValid, DataOut
  );

  modport slave (
    input  CfgDiv, DivIn, PushValid, PushData,
    output PushReady, Level, Busy, ClkTx, DoutValid, DataOut
  );
endinterface

// File: rtl/bc_serial_tx_fifo.sv
// rtl/bc_serial_tx_fifo.sv - frame FIFO feeding an SBITS-lane serialiser with divided ClkTx
//   Clk   : system clock, rising edge
//   Reset : synchronous, active-high
//   bus   : slave side of bc_serial_tx_fifo_if (push, divider config, serial output)
//   Optional macro BC_TX_PARITY_EN appends a per-lane even-parity beat to every frame.
module bc_serial_tx_fifo #(
  parameter int DWIDTH    = 32,
  parameter int SBITS     = 4,
  parameter int DEPTH     = 4,
  parameter int DIVBITS   = 8,
  parameter int DIV_RESET = 1
) (
  input  logic               Clk,
  input  logic               Reset,
  bc_serial_tx_fifo_if.slave bus
);
  localparam int NB = DWIDTH / SBITS;
`ifdef BC_TX_PARITY_EN
  localparam int NBEATS = NB + 1;
`else
  localparam int NBEATS = NB;
`endif
  localparam int BW = $clog2(NBEATS + 1);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;

  logic [DWIDTH-1:0]  mem [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [LW-1:0]      count, count_n;
  logic               push_ready;
  logic [DIVBITS-1:0] div_q, cur_div, phase_cnt;
  logic [BW-1:0]      beat;
  logic [DWIDTH-1:0]  shreg, shifted, head;
  logic               clk_tx, dout_valid;
  logic [SBITS-1:0]   data_out, next_data;
  logic               push, pop, phase_end, last_beat;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // push_ready reflects the count before this edge, so a push into a full
  // FIFO is refused even if a pop frees a slot on the same edge
  assign push      = bus.PushValid && push_ready;
  assign head      = mem[rd_ptr];
  assign shifted   = shreg << SBITS;
  assign last_beat = (beat == BW'(NBEATS - 1));
  assign phase_end = (phase_cnt == cur_div - DIVBITS'(1));
  assign count_n   = (push && !pop) ? count + LW'(1) :
                     (!push && pop) ? count - LW'(1) : count;

`ifdef BC_TX_PARITY_EN
  logic [SBITS-1:0] par_q;

  function automatic logic [SBITS-1:0] lane_parity(input logic [DWIDTH-1:0] f);
    logic [SBITS-1:0] acc;
    acc = '0;
    for (int i = 0; i < NB; i++) acc ^= f[i*SBITS +: SBITS];
    return acc;
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset)    par_q <= '0;
    else if (pop) par_q <= lane_parity(head);
  end

  assign next_data = (beat == BW'(NB - 1)) ? par_q : shifted[DWIDTH-1 -: SBITS];
`else
  assign next_data = shifted[DWIDTH-1 -: SBITS];
`endif

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  // IDLE always lasts at least one cycle, which yields the single idle
  // cycle between back-to-back frames
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (phase_end && clk_tx && last_beat) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      push_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count      <= count_n;
      push_ready <= (count_n != LW'(DEPTH));
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= bus.PushData;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q      <= DIVBITS'(DIV_RESET);
      cur_div    <= DIVBITS'(1);
      phase_cnt  <= '0;
      beat       <= '0;
      shreg      <= '0;
      clk_tx     <= 1'b0;
      dout_valid <= 1'b0;
      data_out   <= '0;
    end else begin
      if (bus.CfgDiv && state == IDLE) div_q <= bus.DivIn;
      if (pop) begin
        // divider is latched per frame; D=0 behaves as D=1
        cur_div    <= (div_q == '0) ? DIVBITS'(1) : div_q;
        phase_cnt  <= '0;
        beat       <= '0;
        shreg      <= head;
        clk_tx     <= 1'b0;
        dout_valid <= 1'b1;
        data_out   <= head[DWIDTH-1 -: SBITS];
      end else if (state == SHIFT) begin
        if (!phase_end) begin
          phase_cnt <= phase_cnt + DIVBITS'(1);
        end else begin
          phase_cnt <= '0;
          if (!clk_tx) begin
            clk_tx <= 1'b1;
          end else if (last_beat) begin
            clk_tx     <= 1'b0;
            dout_valid <= 1'b0;
          end else begin
            clk_tx   <= 1'b0;
            beat     <= beat + BW'(1);
            shreg    <= shifted;
            data_out <= next_data;
          end
        end
      end
    end
  end

  assign bus.PushReady = push_ready;
  assign bus.Level     = count;
  assign bus.Busy      = (state == SHIFT);
  assign bus.ClkTx     = clk_tx;
  assign bus.DoutValid = dout_valid;
  assign bus.DataOut   = data_out;
endmodule
